// File: rtl/fifo_width_conv.sv
// Narrow-to-wide synchronous FIFO: DATA_IN_WIDTH-bit writes, RATIO packed words per read.
// First-word fall-through read port, occupancy/threshold flags, sticky error flags, flush.
module fifo_width_conv #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int RATIO         = 2,
  parameter int ADDR_WIDTH    = 4,
  parameter int AF_MARGIN     = 2,
  parameter int AE_MARGIN     = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           flush_i,
  input  logic                           write_i,
  input  logic [DATA_IN_WIDTH-1:0]       wr_data_i,
  input  logic                           read_i,
  output logic [DATA_IN_WIDTH*RATIO-1:0] rd_data_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic                           almost_full_o,
  output logic                           almost_empty_o,
  output logic [ADDR_WIDTH:0]            count_o,
  output logic                           overflow_o,
  output logic                           underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] RATIO_C = PW'(RATIO);
  localparam logic [PW-1:0] AF_TH   = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] AE_TH   = PW'(AE_MARGIN);

  logic [DATA_IN_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic                     wr_acc;
  logic                     rd_acc;

  // The wrap bit makes a plain modular difference the exact occupancy.
  assign count_o        = wr_ptr - rd_ptr;
  assign full_o         = (count_o == DEPTH_C);
  assign empty_o        = (count_o < RATIO_C);
  assign almost_full_o  = (count_o >= AF_TH);
  assign almost_empty_o = (count_o <= AE_TH);

  assign wr_acc = write_i & ~full_o;
  assign rd_acc = read_i & ~empty_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + RATIO_C;
      if (write_i && full_o) overflow_o <= 1'b1;
      if (read_i && empty_o) underflow_o <= 1'b1;
    end
  end

  // Storage survives a flush; only reset clears it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc && !flush_i) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
    end
  end

  // Index arithmetic is ADDR_WIDTH bits wide, so lanes wrap with the memory.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign rd_data_o[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] =
      mem[rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k)];
  end

endmodule

// File: doc/fifo_width_conv.md
Name: fifo_width_conv

Overview:
- Synchronous FIFO with integrated storage and narrow-to-wide data width conversion.
- Accepts DATA_IN_WIDTH-bit words on the write side and presents RATIO packed words per read, oldest word in the least-significant lane.
- Parametrised successor to the single-width FIFO controller. Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
- Sits between byte-oriented producers and wider datapath consumers.

Parameters:
- DATA_IN_WIDTH, 8: write word width in bits.
- RATIO, 2: narrow words per read word. Power of two, 1..8.
- ADDR_WIDTH, 4: DEPTH = 2**ADDR_WIDTH narrow words. DEPTH must be >= 2*RATIO and a multiple of RATIO.
- AF_MARGIN, 2: almost_full_o asserts when count_o >= DEPTH-AF_MARGIN.
- AE_MARGIN, 2: almost_empty_o asserts when count_o <= AE_MARGIN.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of pointers and flags.
- write_i  in  1  write request.
- wr_data_i  in  DATA_IN_WIDTH  write word.
- read_i  in  1  read request.
- rd_data_o  out  DATA_IN_WIDTH*RATIO  packed read word.
- empty_o  out  1  fewer than RATIO words stored.
- full_o  out  1  DEPTH words stored.
- almost_full_o  out  1  threshold flag.
- almost_empty_o  out  1  threshold flag.
- count_o  out  ADDR_WIDTH+1  occupancy in narrow words.
- overflow_o  out  1  sticky: write while full.
- underflow_o  out  1  sticky: read while empty.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_ni=0), effective immediately and independent of clk_i:
  - wr_ptr=0, rd_ptr=0, all storage=0.
  - count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
  - overflow_o=0, underflow_o=0, rd_data_o=0.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits in narrow-word units, with a wrap bit.
  - count_o = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Flags are combinational from the registered pointers:
  - full_o = (count_o == DEPTH).
  - empty_o = (count_o < RATIO).
- Write accept = write_i & ~full_o. On the rising edge: mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i, then wr_ptr += 1.
- Read accept = read_i & ~empty_o. On the rising edge: rd_ptr += RATIO.
- Read data is first-word fall-through:
  - rd_data_o lane k (bits k*DATA_IN_WIDTH +: DATA_IN_WIDTH) = mem[(rd_ptr+k) mod DEPTH], for k = 0..RATIO-1.
  - Valid whenever empty_o=0. Shows the last-addressed contents when empty. No read latency.
- Simultaneous accepted read and write: both take effect in the same cycle; count_o changes by 1-RATIO.
- Each accept decision uses the flags from the start of the cycle.
  - Write while full is dropped, even when a read is accepted the same cycle.
  - Read while empty is ignored, even when a write is accepted the same cycle.
- overflow_o sets on write_i & full_o. underflow_o sets on read_i & empty_o. Both stay set until reset or flush_i.
- Wrap-around: address index = pointer[ADDR_WIDTH-1:0]. Wide reads spanning the top of memory are not allowed because DEPTH is a multiple of RATIO.
- flush_i=1 at a rising edge:
  - Pointers and sticky flags clear; storage is retained.
  - flush_i takes priority over write_i and read_i in the same cycle.
- Reset asserted mid-operation discards all contents. The next accepted write goes to address 0.

Test Plan (defaults: DATA_IN_WIDTH=8, RATIO=2, ADDR_WIDTH=4):
1. Assert reset_ni=0 for 2 cycles, then release -> empty_o=1, full_o=0, count_o=0, almost_empty_o=1, overflow_o=0, underflow_o=0.
2. Write 0x01, then 0x02 ->
   - after the first write: count_o=1, empty_o=1.
   - after the second write: count_o=2, empty_o=0, rd_data_o=0x0201.
3. Write 0x00..0x0F, then a 17th write of 0xAA ->
   - full_o=1 after the 16th write.
   - almost_full_o=1 from count_o=14.
   - 17th write dropped, count_o stays 16, overflow_o=1.
4. From state 3, issue 9 consecutive reads ->
   - reads 1..8 return 0x0100, 0x0302, ..., 0x0F0E.
   - empty_o=1 after read 8.
   - read 9 leaves count_o=0 and sets underflow_o=1.
5. Drive count_o to 15 (wr_ptr past wrap), then write_i=1 and read_i=1 together -> both accepted, count_o=14, rd_data_o advances correctly across the pointer wrap.
6. Mid-operation flush and reset ->
   - flush_i=1 with write_i=1 -> count_o=0, overflow_o=0, write not stored.
   - reset_ni=0 asserted between clock edges -> outputs return to reset values before the next edge.
